// File: rtl/gtech_rr_grant_decoder_if.sv
// Request/grant bundle between N requesters and the grant decoder.
// REQ in; GNT, GNT_IDX, GNT_VLD, PREEMPT out.
interface gtech_rr_grant_decoder_if #(
  parameter int N    = 4,
  parameter int IDXW = 2
);
  logic [N-1:0]    REQ;
  logic [N-1:0]    GNT;
  logic [IDXW-1:0] GNT_IDX;
  logic            GNT_VLD;
  logic            PREEMPT;

  modport master (
    output REQ,
    input  GNT,
    input  GNT_IDX,
    input  GNT_VLD,
    input  PREEMPT
  );

  modport slave (
    input  REQ,
    output GNT,
    output GNT_IDX,
    output GNT_VLD,
    output PREEMPT
  );
endinterface

// File: rtl/gtech_rr_grant_decoder.sv
// Round-robin request-to-grant decoder, registered one-hot grant.
// CP clk, CD async clear (low); bus: REQ in, GNT/GNT_IDX/GNT_VLD/PREEMPT out.
module gtech_rr_grant_decoder #(
  parameter int N        = 4,
  parameter int IDXW     = 2,
  parameter int HOLD_MAX = 16,
  parameter int CNTW     = 5
) (
  input logic                    CP,
  input logic                    CD,
  gtech_rr_grant_decoder_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            pre_q, pre_d;

  logic            hit;
  logic [IDXW-1:0] pick;
  int              j;

  // Search starts just after the last owner, so it ranks last.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    j    = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!hit && bus.REQ[j]) begin
        hit  = 1'b1;
        pick = IDXW'(j);
      end
    end
  end

  logic own_req;
  logic others;
  logic tmo;

  assign own_req = bus.REQ[idx_q];
  assign others  = |(bus.REQ & ~gnt_q);
  assign tmo     = (HOLD_MAX != 0)
                && (cnt_q == CNTW'(HOLD_MAX))
                && others;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d     = GRANT;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          idx_d       = pick;
          ptr_d       = pick;
          cnt_d       = CNTW'(1);
        end
      end
      GRANT: begin
        // Release wins over timeout in the same cycle.
        if (!own_req) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (tmo) begin
          state_d = IDLE;
          gnt_d   = '0;
          pre_d   = 1'b1;
        end else if (cnt_q < CNTW'(HOLD_MAX)) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q <= IDLE;
      ptr_q   <= IDXW'(N - 1);
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      pre_q   <= pre_d;
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.GNT_IDX = idx_q;
  assign bus.GNT_VLD = |gnt_q;
  assign bus.PREEMPT = pre_q;

endmodule

// File: tb/tb_gtech_rr_grant_decoder.sv
// Bench for gtech_rr_grant_decoder: table, corner sequences, random vs model.
// Model picks the nearest requester after the pointer by modular distance.
module tb_gtech_rr_grant_decoder;
  localparam int N    = 4;
  localparam int IDXW = 2;
  localparam int HM   = 16;
  localparam int CNTW = 5;

  logic cp;
  logic cd;

  gtech_rr_grant_decoder_if #(.N(N), .IDXW(IDXW)) bus_if ();

  gtech_rr_grant_decoder #(
    .N(N), .IDXW(IDXW), .HOLD_MAX(HM), .CNTW(CNTW)
  ) dut (
    .CP (cp),
    .CD (cd),
    .bus(bus_if)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  int n_vec;
  int n_err;

  int m_own;
  int m_ptr;
  int m_cnt;
  int m_idx;
  bit m_pre;

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] idx;
    logic            vld;
    logic            pre;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1;
    m_ptr = N - 1;
    m_cnt = 0;
    m_idx = 0;
    m_pre = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int best;
    int bd;
    int d;
    m_pre = 0;
    if (m_own < 0) begin
      best = -1;
      bd   = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr - 1 + 2 * N) % N;
        if (r[i] && d < bd) begin
          bd   = d;
          best = i;
        end
      end
      if (best >= 0) begin
        m_own = best;
        m_idx = best;
        m_ptr = best;
        m_cnt = 1;
      end
    end else if (!r[m_own]) begin
      m_own = -1;
    end else if (HM != 0 && m_cnt == HM
                 && (int'(r) & ~(1 << m_own)) != 0) begin
      m_own = -1;
      m_pre = 1;
    end else if (m_cnt < HM) begin
      m_cnt++;
    end
  endtask

  function automatic int m_gnt();
    return (m_own < 0) ? 0 : (1 << m_own);
  endfunction

  task automatic chk_model();
    chk("m_gnt", int'(bus_if.GNT), m_gnt());
    chk("m_vld", int'(bus_if.GNT_VLD), (m_own >= 0) ? 1 : 0);
    chk("m_idx", int'(bus_if.GNT_IDX), m_idx);
    chk("m_pre", int'(bus_if.PREEMPT), int'(m_pre));
  endtask

  task automatic cyc(input logic [N-1:0] r);
    bus_if.REQ = r;
    @(posedge cp);
    model_step(r);
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    bus_if.REQ = '0;
    #2;
    cd = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt", int'(bus_if.GNT), 0);
    chk("rst_vld", int'(bus_if.GNT_VLD), 0);
    chk("rst_idx", int'(bus_if.GNT_IDX), 0);
    chk("rst_pre", int'(bus_if.PREEMPT), 0);
    @(negedge cp);
    @(negedge cp);
    cd = 1'b1;
  endtask

  int hi_cnt;
  int pre_cnt;
  int pre_at;
  int g0_at;
  int bad;
  int k;
  logic [N-1:0] r;
  logic [N-1:0] prev_g;

  initial begin
    n_vec = 0;
    n_err = 0;
    cd    = 1'b1;
    bus_if.REQ = '0;
    model_reset();

    tbl[0]  = '{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[1]  = '{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[2]  = '{4'b1000, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[3]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tbl[5]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{4'b0100, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[9]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};

    // Table: first grant after reset, then pointer progression.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].req);
      chk($sformatf("tbl%0d_gnt", i), int'(bus_if.GNT), int'(tbl[i].gnt));
      chk($sformatf("tbl%0d_vld", i), int'(bus_if.GNT_VLD), int'(tbl[i].vld));
      chk($sformatf("tbl%0d_pre", i), int'(bus_if.PREEMPT), int'(tbl[i].pre));
      if (tbl[i].vld)
        chk($sformatf("tbl%0d_idx", i), int'(bus_if.GNT_IDX), int'(tbl[i].idx));
    end

    // Round robin 0,1,2,3,0 with one idle cycle between grants.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      k = i % N;
      cyc(4'b1111);
      chk("rr_gnt", int'(bus_if.GNT), 1 << k);
      cyc(4'b1111);
      chk("rr_hold", int'(bus_if.GNT), 1 << k);
      r = 4'b1111;
      r[k] = 1'b0;
      cyc(r);
      chk("rr_gap", int'(bus_if.GNT), 0);
    end

    // Timeout preemption of requester 2 by requester 0.
    do_reset();
    hi_cnt  = 0;
    pre_cnt = 0;
    pre_at  = -1;
    g0_at   = -1;
    for (int c = 0; c < 24; c++) begin
      cyc((c >= 5) ? 4'b0101 : 4'b0100);
      if (bus_if.GNT == 4'b0100) hi_cnt++;
      if (bus_if.PREEMPT) begin
        pre_cnt++;
        pre_at = c;
        chk("to_pre_gnt0", int'(bus_if.GNT), 0);
      end
      if (g0_at < 0 && bus_if.GNT == 4'b0001) g0_at = c;
    end
    chk("to_hi_cnt", hi_cnt, 16);
    chk("to_pre_cnt", pre_cnt, 1);
    chk("to_next", g0_at, pre_at + 1);

    // Solo owner is never preempted; a newcomer preempts at once.
    do_reset();
    bad     = 0;
    pre_cnt = 0;
    cyc(4'b1000);
    for (int c = 0; c < 100; c++) begin
      cyc(4'b1000);
      if (bus_if.GNT != 4'b1000) bad++;
      if (bus_if.PREEMPT) pre_cnt++;
    end
    chk("solo_gnt", bad, 0);
    chk("solo_pre", pre_cnt, 0);
    cyc(4'b1001);
    chk("solo_late_pre", int'(bus_if.PREEMPT), 1);
    cyc(4'b1001);
    chk("solo_late_gnt", int'(bus_if.GNT), 4'b0001);

    // Release on the saturating edge beats timeout.
    do_reset();
    cyc(4'b0010);
    for (int c = 0; c < HM - 1; c++) cyc(4'b0011);
    chk("rel_still", int'(bus_if.GNT), 4'b0010);
    cyc(4'b0001);
    chk("rel_pre", int'(bus_if.PREEMPT), 0);
    chk("rel_gnt", int'(bus_if.GNT), 0);
    cyc(4'b0001);
    chk("rel_next", int'(bus_if.GNT), 4'b0001);

    // Asynchronous clear mid-grant.
    do_reset();
    cyc(4'b0100);
    cyc(4'b0100);
    chk("ar_pre", int'(bus_if.GNT), 4'b0100);
    #2;
    cd = 1'b0;
    model_reset();
    #1;
    chk("ar_gnt", int'(bus_if.GNT), 0);
    chk("ar_vld", int'(bus_if.GNT_VLD), 0);
    @(negedge cp);
    cd = 1'b1;
    cyc(4'b0110);
    chk("ar_next", int'(bus_if.GNT), 4'b0010);
    chk("ar_idx", int'(bus_if.GNT_IDX), 1);

    // Random traffic vs model, plus break-before-make.
    do_reset();
    r      = '0;
    prev_g = '0;
    bad    = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0)
        r = N'($urandom);
      else if ($urandom_range(0, 3) == 0)
        r[$urandom_range(0, N - 1)] ^= 1'b1;
      cyc(r);
      if (prev_g != '0 && bus_if.GNT != '0 && prev_g != bus_if.GNT)
        bad++;
      prev_g = bus_if.GNT;
    end
    chk("bbm", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
